// File: rtl/b08_sched.sv
// b08_sched: four-requester job scheduler for a shared evaluation core.
// A winner's operand is captured and handed to the core, the core is waited
// on for CORE_LAT cycles, and the result is reported with its owner's index.
// Build option: define B08_SCHED_FIXED_PRIO_EN for fixed-priority arbitration
// (requester 0 highest). The default build uses round-robin arbitration.
module b08_sched #(
  parameter int CORE_LAT = 18
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_din,
  output logic [3:0]  o_gnt,
  output logic        o_done,
  output logic [1:0]  o_done_id,
  output logic [3:0]  o_dout,
  output logic        o_busy,
  output logic        o_core_start,
  output logic [7:0]  o_core_i,
  input  logic [3:0]  i_core_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  // Counter reload: WAIT lasts CORE_LAT cycles, counting CORE_LAT-1 down to 0.
  localparam logic [7:0] LAT_RELOAD = 8'(CORE_LAT - 1);

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_gnt;
  logic       r_done;
  logic [1:0] r_id;
  logic [1:0] r_done_id;
  logic [3:0] r_dout;
  logic [7:0] r_core_i;

  logic       w_win_valid;
  logic [1:0] w_win_idx;

`ifdef B08_SCHED_FIXED_PRIO_EN
  // Fixed priority: the lowest-numbered requesting index wins.
  always_comb begin
    w_win_valid = |i_req;
    w_win_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (i_req[k]) w_win_idx = 2'(k);
    end
  end
`else
  logic [1:0] r_last;

  // Round-robin: scan from last winner + 1 with 2-bit wrap; scanning
  // backwards lets the nearest requesting index overwrite the others.
  always_comb begin
    w_win_valid = |i_req;
    w_win_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (i_req[r_last + 2'(k + 1)]) w_win_idx = r_last + 2'(k + 1);
    end
  end

  // Remember the last winner; reset to 3 so requester 0 is searched first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 2'd3;
    end else if (r_state == S_IDLE && w_win_valid) begin
      r_last <= w_win_idx;
    end
  end
`endif

  // Scheduler FSM: grant, launch the core, count its latency, report result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_gnt     <= 4'd0;
      r_done    <= 1'b0;
      r_id      <= 2'd0;
      r_done_id <= 2'd0;
      r_dout    <= 4'd0;
      r_core_i  <= 8'd0;
    end else begin
      r_gnt  <= 4'd0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win_valid) begin
            r_gnt    <= 4'b0001 << w_win_idx;
            r_core_i <= i_din[{w_win_idx, 3'b000} +: 8];
            r_id     <= w_win_idx;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= LAT_RELOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_dout  <= i_core_o;
            r_state <= S_REPORT;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_done    <= 1'b1;
          r_done_id <= r_id;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_done_id    = r_done_id;
  assign o_dout       = r_dout;
  assign o_core_i     = r_core_i;
  // START is decoded straight from the state so it can only be high in LAUNCH.
  assign o_core_start = (r_state == S_LAUNCH);
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_b08_sched.sv
// Directed testbench for b08_sched: single jobs, withdrawal, reset mid-job,
// arbitration order and a short-latency instance against a constant stub core.
module tb_b08_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  dout;
  logic        busy;
  logic        core_start;
  logic [7:0]  core_i;
  logic [3:0]  core_o;

  logic [3:0]  l_req;
  logic [31:0] l_din;
  logic [3:0]  l_gnt;
  logic        l_done;
  logic [1:0]  l_done_id;
  logic [3:0]  l_dout;
  logic        l_busy;
  logic        l_core_start;
  logic [7:0]  l_core_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  b08_sched #(.CORE_LAT(18)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_din(din),
    .o_gnt(gnt), .o_done(done), .o_done_id(done_id), .o_dout(dout),
    .o_busy(busy), .o_core_start(core_start), .o_core_i(core_i),
    .i_core_o(core_o)
  );

  b08_sched #(.CORE_LAT(2)) u_dut_lat (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(l_req), .i_din(l_din),
    .o_gnt(l_gnt), .o_done(l_done), .o_done_id(l_done_id), .o_dout(l_dout),
    .o_busy(l_busy), .o_core_start(l_core_start), .o_core_i(l_core_i),
    .i_core_o(4'h5)
  );

  // Stub evaluation core: result is 4'hF with bit0 flipped by operand bit0,
  // driven only in the single cycle 18 cycles after START (0 otherwise).
  logic [7:0] c_lat;
  logic [7:0] c_cnt;
  logic       c_run;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_run <= 1'b0; c_cnt <= 8'd0; c_lat <= 8'd0;
    end else if (core_start) begin
      c_run <= 1'b1; c_cnt <= 8'd17; c_lat <= core_i;
    end else if (c_run) begin
      if (c_cnt == 8'd0) c_run <= 1'b0;
      else c_cnt <= c_cnt - 8'd1;
    end
  end
  assign core_o = (c_run && c_cnt == 8'd0) ? (4'hF ^ {3'b000, c_lat[0]}) : 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One job on the main instance; wd bits are raised then withdrawn while busy.
  task automatic job(input logic [3:0] rv, input logic drop, input logic [1:0] exp_id,
                     input logic [3:0] exp_dout, input logic [7:0] exp_ci,
                     input logic [3:0] wd, output int gcyc);
    logic seen;
    int   starts;
    int   lat;
    req  = rv;
    seen = 1'b0;
    gcyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (gnt != 4'd0) seen = 1'b1;
    end
    if (!seen) begin
      check("gnt_timeout", 32'd0, 32'd1);
      return;
    end
    gcyc = cyc;
    check("gnt", 32'(gnt), 32'(4'b0001 << exp_id));
    check("core_start_launch", 32'(core_start), 32'd1);
    check("core_i", 32'(core_i), 32'(exp_ci));
    if (drop) req = req & ~gnt;
    starts = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 3) req = req | wd;
      if (i == 10) req = req & ~wd;
      if (core_start) starts++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    lat = cyc - gcyc;
    check("latency", 32'(lat), 32'd20);
    check("done_id", 32'(done_id), 32'(exp_id));
    check("dout", 32'(dout), 32'(exp_dout));
    check("core_start_outside", 32'(starts), 32'd0);
    $display("job req=%b granted=%0d done_id=%0d dout=%h latency=%0d", rv, exp_id, done_id, dout, lat);
    if (wd != 4'd0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("withdrawn_no_gnt", 32'(gnt), 32'd0);
      end
    end
  endtask

  logic [1:0] exp_rr   [0:4];
  logic [1:0] exp_prio [0:2];
  int g;
  int g_prev;
  int rel_cyc;

  initial begin
`ifdef B08_SCHED_FIXED_PRIO_EN
    exp_rr[0] = 2'd0; exp_rr[1] = 2'd0; exp_rr[2] = 2'd0; exp_rr[3] = 2'd0; exp_rr[4] = 2'd0;
    exp_prio[0] = 2'd1; exp_prio[1] = 2'd1; exp_prio[2] = 2'd1;
`else
    exp_rr[0] = 2'd0; exp_rr[1] = 2'd1; exp_rr[2] = 2'd2; exp_rr[3] = 2'd3; exp_rr[4] = 2'd0;
    exp_prio[0] = 2'd1; exp_prio[1] = 2'd3; exp_prio[2] = 2'd1;
`endif
    rst_n = 1'b0; req = 4'd0; din = 32'd0; l_req = 4'd0; l_din = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_core_i", 32'(core_i), 32'd0);
    rst_n = 1'b1;

    // Single job, operand 0x00 -> 4'hF.
    din = 32'h0000_0000;
    job(4'b0001, 1'b1, 2'd0, 4'hF, 8'h00, 4'b0000, g);
    // Second operand 0xFF -> 4'hE, with requester 1 raised and withdrawn while busy.
    din = 32'h00FF_0000;
    job(4'b0100, 1'b1, 2'd2, 4'hE, 8'hFF, 4'b0010, g);

    // Reset in the 5th WAIT cycle of a running job.
    din = 32'h0000_0001;
    req = 4'b0001;
    g = 0;
    for (int i = 0; i < 10 && g == 0; i++) begin
      @(negedge clk);
      if (gnt != 4'd0) g = 1;
    end
    check("mid_gnt", 32'(gnt), 32'd1);
    req = 4'd0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_done_id", 32'(done_id), 32'd0);
    check("mid_rst_core_i", 32'(core_i), 32'd0);
    check("mid_rst_core_start", 32'(core_start), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      check("mid_rst_no_done", 32'(done), 32'd0);
    end
    rel_cyc = cyc;
    din = 32'h5A00_0000;
    job(4'b1000, 1'b1, 2'd3, 4'hF, 8'h5A, 4'b0000, g);
    check("first_edge_gnt", 32'(g - rel_cyc), 32'd1);

    // All four requesting, held high: arbitration order and grant spacing.
    din = 32'h0302_0100;
    g_prev = 0;
    for (int i = 0; i < 5; i++) begin
      job(4'b1111, 1'b0, exp_rr[i], exp_rr[i][0] ? 4'hE : 4'hF, 8'(exp_rr[i]), 4'b0000, g);
      if (i > 0) check("grant_spacing", 32'(g - g_prev), 32'd21);
      g_prev = g;
    end
    for (int i = 0; i < 3; i++) begin
      job(4'b1010, 1'b0, exp_prio[i], 4'hE, 8'(exp_prio[i]), 4'b0000, g);
    end
    req = 4'd0;

    // Short-latency instance against a constant core output of 4'h5.
    @(negedge clk);
    l_din = 32'h0000_0033;
    l_req = 4'b0001;
    g = 0;
    for (int i = 0; i < 10 && g == 0; i++) begin
      @(negedge clk);
      if (l_gnt != 4'd0) g = cyc;
    end
    if (g == 0) check("lat_gnt_timeout", 32'd0, 32'd1);
    check("lat_gnt", 32'(l_gnt), 32'd1);
    check("lat_core_start", 32'(l_core_start), 32'd1);
    check("lat_core_i", 32'(l_core_i), 32'h33);
    l_req = 4'd0;
    g_prev = 0;
    rel_cyc = 0;
    for (int i = 0; i < 10 && rel_cyc == 0; i++) begin
      @(negedge clk);
      if (l_core_start) g_prev++;
      if (l_done) rel_cyc = cyc;
    end
    check("lat_latency", 32'(rel_cyc - g), 32'd4);
    check("lat_dout", 32'(l_dout), 32'h5);
    check("lat_done_id", 32'(l_done_id), 32'd0);
    check("lat_core_start_outside", 32'(g_prev), 32'd0);
    $display("job lat2 req=0001 done_id=%0d dout=%h latency=%0d", l_done_id, l_dout, rel_cyc - g);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/b08_sched.md
B08_SCHED -- requirements
Module: b08_sched

Interface
- REQ-001: Parameter CORE_LAT, default 18: number of WAIT cycles between the core START pulse and the CORE_O sample; legal range 2..255.
- REQ-002: CLOCK  input  1  single clock; all state updates on rising edge.
- REQ-003: RESET_N  input  1  asynchronous, active-low reset.
- REQ-004: REQ  input  4  per-requester request level; held high until the matching GNT bit pulses.
- REQ-005: DIN  input  32  requester operands; DIN[8k+7:8k] belongs to requester k.
- REQ-006: GNT  output  4  one-hot, one-cycle pulse; the operand of the granted requester was captured on that edge.
- REQ-007: DONE  output  1  one-cycle pulse; DOUT and DONE_ID valid in the same cycle.
- REQ-008: DONE_ID  output  2  index of the requester that owns the current result.
- REQ-009: DOUT  output  4  evaluation result; holds its value until the next DONE.
- REQ-010: BUSY  output  1  high in every state except IDLE.
- REQ-011: CORE_START  output  1  drives the evaluation core START input.
- REQ-012: CORE_I  output  8  drives the evaluation core I input; stable from LAUNCH until the next grant.
- REQ-013: CORE_O  input  4  evaluation core O output.

Function
- REQ-014: The FSM SHALL have states IDLE, LAUNCH, WAIT and REPORT.
- REQ-015: IDLE, with no REQ bit high: stay in IDLE.
- REQ-016: IDLE, with any REQ bit high: select one winner (see REQ-023), register its DIN slice into CORE_I, register its index, pulse the winner's GNT bit, go to LAUNCH.
- REQ-017: LAUNCH: assert CORE_START for exactly this one cycle, load the 8-bit counter with CORE_LAT-1, go to WAIT.
- REQ-018: WAIT: decrement the counter each cycle; in the cycle where the counter is 0, register CORE_O into DOUT and go to REPORT.
- REQ-019: REPORT: pulse DONE, present DONE_ID, go to IDLE.
- REQ-020: Latency: a grant edge at cycle t gives LAUNCH at t+1 and DONE at t+CORE_LAT+2; with the default value, DONE comes 20 cycles after the grant.
- REQ-021: Requests arriving while BUSY SHALL be ignored and not lost; they are arbitrated on the next IDLE cycle. The scheduler never gives back-to-back grants, so there is at least one IDLE cycle between REPORT and the next grant.
- REQ-022: A REQ bit that drops before its grant SHALL be treated as withdrawn, with no grant and no result.
- REQ-023: Default arbitration SHALL be round-robin. The search starts at (last granted index + 1) mod 4 and wraps from 3 to 0.
- REQ-024: CORE_START SHALL never be high outside LAUNCH. CORE_O SHALL be sampled only in the counter==0 WAIT cycle.

Reset
- REQ-025: When RESET_N is low, the block SHALL asynchronously enter IDLE and clear the following: GNT=0, DONE=0, DONE_ID=0, DOUT=0, BUSY=0, CORE_START=0, CORE_I=0, counter=0.
- REQ-026: Reset SHALL set the round-robin pointer so that requester 0 has highest priority.
- REQ-027: Reset mid-operation SHALL discard the in-flight job with no DONE pulse. The evaluation core SHALL share the same reset so that both blocks restart together.
- REQ-028: Reset release SHALL be synchronous to CLOCK at the system level. The first grant is possible on the first rising edge after release.

Configuration
- REQ-029: Macro B08_SCHED_FIXED_PRIO_EN selects the arbitration mode.
- REQ-030: With the macro defined, arbitration SHALL be fixed priority, requester 0 highest and requester 3 lowest, and the round-robin pointer logic is absent.
- REQ-031: Without the macro, round-robin arbitration per REQ-023 applies.
- REQ-032: All other behaviour SHALL be identical in both modes.

Verification
- REQ-033: Single job. Stimulus: after reset, REQ=4'b0001, DIN[7:0]=8'h00. Response: GNT=4'b0001 after one edge; CORE_START high for 1 cycle; DONE 20 cycles after the grant with DONE_ID=0 and DOUT=4'hF.
- REQ-034: Second operand. Stimulus: REQ=4'b0100, DIN[23:16]=8'hFF. Response: DONE_ID=2, DOUT=4'hE.
- REQ-035: Round-robin fairness. Stimulus: REQ=4'b1111 held high, each bit re-asserted after its grant. Response: grant order 0,1,2,3,0; consecutive grants 21 cycles apart.
- REQ-036: Fixed-priority mode. Stimulus: macro defined, REQ=4'b1010 held high. Response: requester 1 granted every time; requester 3 starved.
- REQ-037: Reset mid-operation. Stimulus: RESET_N low in the 5th WAIT cycle. Response: all outputs 0 immediately and no DONE; a fresh REQ=4'b1000 after release gets GNT=4'b1000 on the first edge.
- REQ-038: Latency parameter. Stimulus: CORE_LAT=2 against a stub core that holds CORE_O=4'h5. Response: DONE 4 cycles after the grant with DOUT=4'h5; CORE_START never high outside LAUNCH.
